tilemap_writer: RTL

- Producer-side write port for the 32x32 tile/character RAM that the video scan-out reads.
- Accepts write and read-modify-write commands over a valid/ready handshake and buffers them in a small FIFO.
- Commits commands to the single-port synchronous RAM only while the display is not fetching (the blanking window), so the scan-out never sees bus contention.
- Sits between game/CPU logic and the RAM address/data mux in the top level.

---
 rtl/tilemap_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tilemap_writer.sv
`default_nettype none
// ============================================================================
// Module   : tilemap_writer
// Brief    : Queued write / read-modify-write port into the tile RAM; commits
//            only while the display is blanked. Optional CLEAR op via the
//            TILEWR_CLEAR_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tilemap_writer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_on,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ram_own,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    localparam int               c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE  = 1;
    localparam logic [c_PTR_W:0] c_PTR_FULL = {1'b1, {c_PTR_W{1'b0}}};

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_INC   = 2'b01;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WR   = 3'd1;
    localparam logic [2:0] c_ST_RD   = 3'd2;
    localparam logic [2:0] c_ST_MOD  = 3'd3;
    localparam logic [2:0] c_ST_HOLD = 3'd4;
`ifdef TILEWR_CLEAR_EN
    localparam logic [2:0]        c_ST_CLR   = 3'd5;
    localparam logic [ADDR_W-1:0] c_CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] c_CNT_LAST = '1;
    logic [ADDR_W-1:0] r_clr_cnt;
`endif

    logic [1:0]        r_fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;

    logic [2:0]        r_state;
    logic [1:0]        r_cmd_op;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_data;

    logic w_win;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drive;
    logic w_write;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_rd_idx;
    logic [1:0]         w_head_op;

    assign w_win     = !display_on;
    assign w_wr_idx  = r_wr_ptr[c_PTR_W-1:0];
    assign w_rd_idx  = r_rd_ptr[c_PTR_W-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = ((r_wr_ptr ^ r_rd_ptr) == c_PTR_FULL);
    assign w_head_op = r_fifo_op[w_rd_idx];

    // Ready depends only on registered pointers, so a pop never frees a slot
    // within the same cycle.
    assign req_ready = !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == c_ST_IDLE) && !w_empty && w_win;
    assign busy      = !w_empty || (r_state != c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[w_wr_idx]   <= req_op;
            r_fifo_addr[w_wr_idx] <= req_addr;
            r_fifo_data[w_wr_idx] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= c_ST_IDLE;
            r_cmd_op   <= '0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
`ifdef TILEWR_CLEAR_EN
            r_clr_cnt  <= '0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_cmd_op   <= w_head_op;
                r_cmd_addr <= r_fifo_addr[w_rd_idx];
                r_cmd_data <= r_fifo_data[w_rd_idx];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        if (w_head_op == c_OP_WRITE) begin
                            r_state <= c_ST_WR;
                        end else if (w_head_op == c_OP_CLEAR) begin
`ifdef TILEWR_CLEAR_EN
                            r_state   <= c_ST_CLR;
                            r_clr_cnt <= '0;
`else
                            r_state <= c_ST_IDLE;
`endif
                        end else begin
                            r_state <= c_ST_RD;
                        end
                    end
                end
                // A window closing mid-write retries rather than dropping data.
                c_ST_WR:   if (w_win) r_state <= c_ST_IDLE;
                c_ST_RD:   r_state <= w_win ? c_ST_MOD  : c_ST_HOLD;
                c_ST_MOD:  r_state <= w_win ? c_ST_IDLE : c_ST_HOLD;
                c_ST_HOLD: if (w_win) r_state <= c_ST_RD;
`ifdef TILEWR_CLEAR_EN
                c_ST_CLR: begin
                    if (w_win) begin
                        r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
                        if (r_clr_cnt == c_CNT_LAST) r_state <= c_ST_IDLE;
                    end
                end
`endif
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Bus outputs are gated by the live window and by reset; MOD must be
    // combinational because ram_dout only becomes valid in that cycle.
    always_comb begin
        w_drive  = 1'b0;
        w_write  = 1'b0;
        ram_addr = r_cmd_addr;
        ram_din  = r_cmd_data;
        case (r_state)
            c_ST_WR: begin
                w_drive = 1'b1;
                w_write = 1'b1;
            end
            c_ST_RD: begin
                w_drive = 1'b1;
            end
            c_ST_MOD: begin
                w_drive = 1'b1;
                w_write = 1'b1;
                ram_din = (r_cmd_op == c_OP_INC) ? (ram_dout + r_cmd_data)
                                                 : (ram_dout ^ r_cmd_data);
            end
`ifdef TILEWR_CLEAR_EN
            c_ST_CLR: begin
                w_drive  = 1'b1;
                w_write  = 1'b1;
                ram_addr = r_clr_cnt;
            end
`endif
            default: begin
                w_drive = 1'b0;
            end
        endcase
        ram_own = w_drive && w_win && !reset;
        ram_we  = w_write && w_win && !reset;
    end

endmodule
`default_nettype wire
